// File: rtl/mips_isa_pkg.sv
// MIPS instruction-set constants shared by the instruction loader and the datapath control decoder.
// Mnemonic codes, opcode/funct encodings, loader states and word-packing helpers.
package mips_isa_pkg;

   typedef enum logic [4:0] {
      MN_ADD  = 5'd0,
      MN_SUB  = 5'd1,
      MN_AND  = 5'd2,
      MN_OR   = 5'd3,
      MN_NOR  = 5'd4,
      MN_SLT  = 5'd5,
      MN_XOR  = 5'd6,
      MN_ADDI = 5'd7,
      MN_LW   = 5'd8,
      MN_SW   = 5'd9,
      MN_BEQ  = 5'd10,
      MN_BNE  = 5'd11,
      MN_J    = 5'd12,
      MN_ANDI = 5'd13,
      MN_ORI  = 5'd14,
      MN_XORI = 5'd15
   } mnem_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_XOR = 6'b100110;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] pack_j(input logic [25:0] target);
      return {OP_J, target};
   endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// Combinational MIPS encoder: symbolic mnemonic plus register/immediate fields -> 32-bit word.
// Codes outside the defined mnemonic set are flagged illegal and produce a zero word.
module mips_instr_encoder
   import mips_isa_pkg::*;
(
   input  logic [4:0]  i_mnem,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output logic [31:0] o_word,
   output logic        o_legal
);

   always_comb begin
      o_word  = 32'd0;
      o_legal = 1'b1;
      case (i_mnem)
         MN_ADD:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_ADD);
         MN_SUB:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_SUB);
         MN_AND:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_AND);
         MN_OR:   o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_OR);
         MN_NOR:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_NOR);
         MN_SLT:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_SLT);
         MN_XOR:  o_word = pack_r(i_rs, i_rt, i_rd, FUNCT_XOR);
         // Immediates and branch offsets go through untouched; sign handling is the datapath's job.
         MN_ADDI: o_word = pack_i(OP_ADDI, i_rs, i_rt, i_imm);
         MN_LW:   o_word = pack_i(OP_LW,   i_rs, i_rt, i_imm);
         MN_SW:   o_word = pack_i(OP_SW,   i_rs, i_rt, i_imm);
         MN_BEQ:  o_word = pack_i(OP_BEQ,  i_rs, i_rt, i_imm);
         MN_BNE:  o_word = pack_i(OP_BNE,  i_rs, i_rt, i_imm);
         MN_J:    o_word = pack_j(i_target);
         MN_ANDI: o_word = pack_i(OP_ANDI, i_rs, i_rt, i_imm);
         MN_ORI:  o_word = pack_i(OP_ORI,  i_rs, i_rt, i_imm);
         MN_XORI: o_word = pack_i(OP_XORI, i_rs, i_rt, i_imm);
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction-memory loader: accepts symbolic instructions over valid/ready, encodes them and
// writes them to consecutive word addresses starting at BASE_ADDR, one word per cycle.
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         finish,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [4:0]                   in_mnem,
   input  logic [4:0]                   in_rs,
   input  logic [4:0]                   in_rt,
   input  logic [4:0]                   in_rd,
   input  logic [15:0]                  in_imm,
   input  logic [25:0]                  in_target,
   output logic                         im_we,
   output logic [ADDR_W-1:0]            im_addr,
   output logic [31:0]                  im_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         busy,
   output logic                         full,
   output logic                         err,
   output logic [$clog2(DEPTH+1)-1:0]   err_index
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   state_t              r_state;
   state_t              w_next_state;
   logic                w_accept;
   logic                w_legal;
   logic [31:0]         w_word;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_last;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_err_index;

   mips_instr_encoder u_encoder (
      .i_mnem   (in_mnem),
      .i_rs     (in_rs),
      .i_rt     (in_rt),
      .i_rd     (in_rd),
      .i_imm    (in_imm),
      .i_target (in_target),
      .o_word   (w_word),
      .o_legal  (w_legal)
   );

   // start and finish both steal the cycle, so a beat offered alongside them is held off.
   assign in_ready = (r_state == ST_RUN) && !start && !finish;
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_count == CNT_W'(DEPTH - 1));
   assign w_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(r_count);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (start) begin
         w_next_state = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  if (!w_legal) begin
                     w_next_state = ST_ERR;
                  end else if (w_last) begin
                     w_next_state = ST_FULL;
                  end
               end else if (finish) begin
                  w_next_state = ST_IDLE;
               end
            end
            ST_FULL: begin
               if (finish) begin
                  w_next_state = ST_IDLE;
               end
            end
            default: w_next_state = r_state;
         endcase
      end
   end

   // Write port register: one-cycle im_we pulse per accepted legal beat, address/data hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we        <= 1'b0;
         r_addr      <= ADDR_W'(BASE_ADDR);
         r_wdata     <= 32'd0;
         r_count     <= '0;
         r_err_index <= '0;
      end else begin
         r_we <= 1'b0;
         if (start) begin
            r_count     <= '0;
            r_err_index <= '0;
         end else if (w_accept) begin
            if (w_legal) begin
               r_we    <= 1'b1;
               r_addr  <= w_addr;
               r_wdata <= w_word;
               r_count <= r_count + 1'b1;
            end else begin
               r_err_index <= r_count;
            end
         end
      end
   end

   assign im_we     = r_we;
   assign im_addr   = r_addr;
   assign im_wdata  = r_wdata;
   assign count     = r_count;
   assign err_index = r_err_index;
   assign busy      = (r_state == ST_RUN);
   assign full      = (r_state == ST_FULL);
   assign err       = (r_state == ST_ERR);

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer side of the instruction path: accepts symbolic instructions (mnemonic code plus fields) over a valid/ready handshake.
- Encodes each one into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses.
- Feeds the same opcode/funct encodings that the datapath control decoder consumes.
- Used for bench program loading and for FPGA boot-time loading from switches or UART.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 64, maximum number of words per load session (1..2^ADDR_W - BASE_ADDR).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  pulse: clear count and errors, enter RUN.
- finish  input  1  pulse: end session, enter IDLE.
- in_valid  input  1  instruction beat valid.
- in_ready  output  1  block can accept beat this cycle.
- in_mnem  input  5  mnemonic code (mnem_t).
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate / branch offset, passed raw.
- in_target  input  26  jump target field, passed raw.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  ADDR_W  write word address.
- im_wdata  output  32  encoded word.
- count  output  $clog2(DEPTH+1)  words written this session.
- busy  output  1  state is RUN.
- full  output  1  state is FULL.
- err  output  1  state is ERR (sticky until start/rst).
- err_index  output  $clog2(DEPTH+1)  value of count when the illegal beat arrived.

Behaviour:
- Reset (rst=1 at edge): state IDLE; im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, err=0, err_index=0. Any pending write is dropped.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready = !start && !finish.
    - Accepted legal beat, count+1==DEPTH -> FULL.
    - Accepted illegal beat -> ERR.
    - finish -> IDLE.
  - FULL: in_ready=0. start -> RUN; finish -> IDLE.
  - ERR: in_ready=0. start -> RUN; finish is ignored.
- start in any state: count=0, err=0, err_index=0, next address BASE_ADDR; a beat on the same cycle is not accepted. start wins over finish.
- Accept = in_valid && in_ready. Latency is 1 cycle: in the cycle after accept, im_we=1, im_addr=BASE_ADDR+count_before, im_wdata=encoded word. count increments in that same cycle.
- Throughput is 1 word per cycle. im_we is a one-cycle pulse per word and 0 otherwise; im_addr/im_wdata hold their last values.
- Encoding:
  - R-type (ADD, SUB, AND, OR, NOR, SLT, XOR): {6'b000000, rs, rt, rd, 5'b00000, funct}. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, NOR 100111, SLT 101010, XOR 100110.
  - I-type: {op, rs, rt, imm}. op: ADDI 001000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ANDI 001100, ORI 001101, XORI 001110.
  - J: {000010, target}.
  - Unused fields of the chosen format are ignored.
- Mnemonic codes 0..15 are, in order: ADD, SUB, AND, OR, NOR, SLT, XOR, ADDI, LW, SW, BEQ, BNE, J, ANDI, ORI, XORI.
- Codes 16..31 are illegal: no write, err_index=count, state goes to ERR. Earlier writes remain in memory.
- Boundaries:
  - The last legal beat at count=DEPTH-1 is written; the block then enters FULL with in_ready=0.
  - Address arithmetic never wraps inside a session.
  - finish on the same cycle as a valid beat: the beat is not accepted; a write still pending from the previous cycle completes.
  - rst mid-session overrides everything.

Decomposition:
- Package mips_isa_pkg:
  - mnem_t enum (5-bit).
  - OP_* and FUNCT_* 6-bit constants; these are shared with the control decoder.
  - state_t {IDLE, RUN, FULL, ERR}.
- One combinational sub-module, mips_instr_encoder: mnemonic plus fields -> 32-bit word and legal flag. The loader registers its output.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221820, count=1.
- Back-to-back ADDI rs=0 rt=8 imm=0x0005, then LW rs=29 rt=4 imm=0x0010, then J target=0x0000004 -> three consecutive writes 0x20080005, 0x8FA40010, 0x08000004 at addresses 0, 1, 2.
- BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF; BNE with the same fields -> 0x1422FFFF; no sign manipulation.
- DEPTH=4: offer 5 valid beats -> exactly 4 writes (addresses 0..3), full=1, in_ready=0, 5th beat held. start -> count=0, writes resume at address 0.
- After 2 writes, in_mnem=20 -> no im_we, err=1, err_index=2, in_ready=0. start clears err.
- rst asserted the cycle after an accept -> im_we=0 next cycle, count=0, state IDLE; start with in_valid the same cycle -> beat not accepted.
